coin_vending_fsm: RTL and testbench

Single-product coin vending controller; item price fixed at 15 units.
- Accepts one coin per clock: 5 or 10 units.
- Asserts a one-cycle vend pulse when accumulated credit reaches 15, returning 5 units of change on overpayment.
- Refunds partial credit when a clock passes with no coin inserted.
- Sits between a coin-acceptor front end and the dispense/change actuators.

---
 rtl/coin_vending_fsm_if.sv | 16 +
 rtl/coin_vending_fsm.sv | 86 ++++++++
 tb/tb_coin_vending_fsm.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/coin_vending_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : coin_vending_fsm_if
// Brief   : Coin-code input and vend/change outputs of the vending controller.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface coin_vending_fsm_if;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  // master is the coin-acceptor / actuator side, slave is the controller
  modport master (output in, input out, input change);
  modport slave  (input in, output out, output change);
endinterface
`default_nettype wire

// File: rtl/coin_vending_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : coin_vending_fsm
// Brief   : Price-15 coin vending controller with registered vend/change.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module coin_vending_fsm (
  input  wire                 clk,
  input  wire                 rst,
  coin_vending_fsm_if.slave   bus
);

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_FIVE = 2'b01;
  localparam logic [1:0] C_TEN  = 2'b10;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_out;
  logic       w_out;
  logic [1:0] r_change;
  logic [1:0] w_change;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S0;
      r_out    <= 1'b0;
      r_change <= C_NONE;
    end else begin
      r_state  <= w_next;
      r_out    <= w_out;
      r_change <= w_change;
    end
  end

  always_comb begin
    w_next   = S0;
    w_out    = 1'b0;
    w_change = C_NONE;
    case (r_state)
      S0: begin
        case (bus.in)
          C_FIVE:  w_next = S1;
          C_TEN:   w_next = S2;
          default: w_next = S0;
        endcase
      end
      S1: begin
        case (bus.in)
          C_NONE: w_change = C_FIVE;
          C_FIVE: w_next   = S2;
          C_TEN:  w_out    = 1'b1;
          default: w_next  = S1;
        endcase
      end
      S2: begin
        case (bus.in)
          C_NONE: w_change = C_TEN;
          C_FIVE: w_out    = 1'b1;
          C_TEN: begin
            w_out    = 1'b1;
            w_change = C_FIVE;
          end
          default: w_next = S2;
        endcase
      end
      // the spare encoding falls back to S0 with quiet outputs
      default: begin
        w_next   = S0;
        w_out    = 1'b0;
        w_change = C_NONE;
      end
    endcase
  end

  assign bus.out    = r_out;
  assign bus.change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_coin_vending_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_coin_vending_fsm
// Brief   : Vector table, corner sequences and random run against a credit model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_coin_vending_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  coin_vending_fsm_if bus ();

  coin_vending_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // credit-in-units reference model
  int         m_credit = 0;
  logic       m_out    = 1'b0;
  logic [1:0] m_change = 2'b00;

  task automatic model_step(input logic r, input logic [1:0] c);
    int v;
    int sum;
    if (r) begin
      m_credit = 0;
      m_out    = 1'b0;
      m_change = 2'b00;
    end else if (c == 2'b00) begin
      m_out    = 1'b0;
      m_change = 2'(m_credit / 5);
      m_credit = 0;
    end else if (c == 2'b11) begin
      m_out    = 1'b0;
      m_change = 2'b00;
    end else begin
      v   = (c == 2'b01) ? 5 : 10;
      sum = m_credit + v;
      if (sum >= 15) begin
        m_out    = 1'b1;
        m_change = 2'((sum - 15) / 5);
        m_credit = 0;
      end else begin
        m_out    = 1'b0;
        m_change = 2'b00;
        m_credit = sum;
      end
    end
  endtask

  task automatic check(input string nm, input logic eo, input logic [1:0] ec);
    total++;
    if (bus.out !== eo || bus.change !== ec) begin
      bad++;
      $display("FAIL %s: got out=%b change=%b, want out=%b change=%b",
               nm, bus.out, bus.change, eo, ec);
    end
  endtask

  // drive one edge; outputs are sampled 1 time unit after it
  task automatic step(input logic r, input logic [1:0] c);
    rst    = r;
    bus.in = c;
    model_step(r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [1:0] c, input logic o, input logic [1:0] ch);
    vec_t v;
    v.rst = r; v.in = c; v.out = o; v.change = ch;
    vecs.push_back(v);
  endtask

  initial begin
    bus.in = 2'b00;

    // reset with a coin present, then idle
    add(1, 2'b10, 0, 2'b00);
    add(0, 2'b00, 0, 2'b00); add(0, 2'b00, 0, 2'b00); add(0, 2'b00, 0, 2'b00);
    // 10 + 5 exact
    add(0, 2'b10, 0, 2'b00); add(0, 2'b01, 1, 2'b00); add(0, 2'b00, 0, 2'b00);
    // 10 + 10 with change
    add(0, 2'b10, 0, 2'b00); add(0, 2'b10, 1, 2'b01); add(0, 2'b00, 0, 2'b00);
    // refunds of 5 and 10
    add(0, 2'b01, 0, 2'b00); add(0, 2'b00, 0, 2'b01);
    add(0, 2'b10, 0, 2'b00); add(0, 2'b00, 0, 2'b10); add(0, 2'b00, 0, 2'b00);
    // held five: vend every third edge
    add(0, 2'b01, 0, 2'b00); add(0, 2'b01, 0, 2'b00); add(0, 2'b01, 1, 2'b00);
    add(0, 2'b01, 0, 2'b00); add(0, 2'b01, 0, 2'b00); add(0, 2'b01, 1, 2'b00);
    // held ten: vend+change every second edge
    add(0, 2'b10, 0, 2'b00); add(0, 2'b10, 1, 2'b01);
    add(0, 2'b10, 0, 2'b00); add(0, 2'b10, 1, 2'b01); add(0, 2'b00, 0, 2'b00);
    // invalid codes hold credit at 5, then exact 15
    add(0, 2'b01, 0, 2'b00); add(0, 2'b11, 0, 2'b00); add(0, 2'b11, 0, 2'b00);
    add(0, 2'b10, 1, 2'b00);
    // invalid at S2 holds 10
    add(0, 2'b10, 0, 2'b00); add(0, 2'b11, 0, 2'b00); add(0, 2'b01, 1, 2'b00);
    // invalid at S0 ignored
    add(0, 2'b11, 0, 2'b00); add(0, 2'b00, 0, 2'b00);
    // reset after a ten discards credit without refund
    add(0, 2'b10, 0, 2'b00); add(1, 2'b00, 0, 2'b00); add(0, 2'b00, 0, 2'b00);
    add(0, 2'b01, 0, 2'b00); add(0, 2'b10, 1, 2'b00); add(0, 2'b00, 0, 2'b00);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].out, vecs[i].change);
    end

    // reset beats a vending transition from S2
    step(0, 2'b10); check("rst_pri_load", 1'b0, 2'b00);
    step(1, 2'b01); check("rst_pri_vend", 1'b0, 2'b00);
    step(0, 2'b00); check("rst_pri_norefund", 1'b0, 2'b00);
    // reset beats a refund from S1
    step(0, 2'b01); check("rst_s1_load", 1'b0, 2'b00);
    step(1, 2'b00); check("rst_s1_norefund", 1'b0, 2'b00);
    step(0, 2'b10); check("rst_s1_fresh", 1'b0, 2'b00);
    step(0, 2'b00); check("rst_s1_refund10", 1'b0, 2'b10);

    // random run against the credit model
    for (int k = 0; k < 500; k++) begin
      logic       r;
      logic [1:0] c;
      r = ($urandom_range(0, 15) == 0);
      c = 2'($urandom_range(0, 3));
      step(r, c);
      check($sformatf("rnd%0d", k), m_out, m_change);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
